// File: rtl/clean_finish_monitor_pkg.sv
// Shared constants for the clean-finish monitor: channel indices, default
// qualification length and the done_id width helper.
package clean_mon_pkg;

  localparam int CH_SELF            = 0;
  localparam int CH_MANUAL          = 1;
  localparam int DEFAULT_MIN_ACTIVE = 3;

  // Width of an index into n channels; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clean_finish_monitor_if.sv
// Signal bundle between the mode controller (master) and the clean-finish
// monitor (slave).
interface clean_finish_monitor_if #(
  parameter int N_CH = 2,
  parameter int ID_W = clean_mon_pkg::id_width(N_CH)
);

  // There is no valid/ready handshake in this bundle. busy_in is a plain level.
  // done_pulse and any_done are single-cycle strobes.
  // pending/overrun stay set until ack[i] is sampled high, and the same edge clears them.
  // done_valid/done_id name the lowest pending channel.
  logic [N_CH-1:0] busy_in;
  logic [N_CH-1:0] ack;
  logic [N_CH-1:0] done_pulse;
  logic            any_done;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overrun;
  logic            done_valid;
  logic [ID_W-1:0] done_id;

  modport master (
    output busy_in, ack,
    input  done_pulse, any_done, pending, overrun, done_valid, done_id
  );

  modport slave (
    input  busy_in, ack,
    output done_pulse, any_done, pending, overrun, done_valid, done_id
  );

endinterface

// File: rtl/clean_finish_channel.sv
// One monitored channel: qualifies a busy fall against a minimum active time.
// Sticky pending/overrun flags exist only when CLEAN_FINISH_STICKY_EN is defined.
module clean_finish_channel
  import clean_mon_pkg::*;
#(
  parameter int MIN_ACTIVE = DEFAULT_MIN_ACTIVE
) (
  input  logic clk_100Hz,
  input  logic rst,
  input  logic busy,
  input  logic ack,
  output logic qualified,
  output logic done_pulse,
  output logic pending,
  output logic overrun
);

  localparam int                CNT_W   = $clog2(MIN_ACTIVE + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MIN_ACTIVE);

  logic             prev;
  logic [CNT_W-1:0] cnt;

  // cnt is the run of high samples up to the previous edge, so it measures
  // the busy period that is ending now.
  assign qualified = prev & ~busy & (cnt == CNT_MAX);

  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      prev       <= 1'b0;
      cnt        <= '0;
      done_pulse <= 1'b0;
    end else begin
      prev       <= busy;
      done_pulse <= qualified;
      if (!busy)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

`ifdef CLEAN_FINISH_STICKY_EN
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A new finish beats a simultaneous ack. Overrun is only raised when
      // the earlier finish has not been acknowledged.
      if (qualified)
        pending <= 1'b1;
      else if (ack)
        pending <= 1'b0;

      if (qualified && pending && !ack)
        overrun <= 1'b1;
      else if (ack)
        overrun <= 1'b0;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign pending    = 1'b0;
  assign overrun    = 1'b0;
`endif

endmodule

// File: rtl/clean_finish_monitor.sv
// Multi-channel clean-finish detector: per-channel qualification, OR'd strobe
// and lowest-index pending encoder (sticky part enabled by CLEAN_FINISH_STICKY_EN).
module clean_finish_monitor
  import clean_mon_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int MIN_ACTIVE = DEFAULT_MIN_ACTIVE,
  parameter int ID_W       = id_width(N_CH)
) (
  input  logic                    clk_100Hz,
  input  logic                    rst,
  clean_finish_monitor_if.slave   bus
);

  logic [N_CH-1:0] qualified;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clean_finish_channel #(
      .MIN_ACTIVE(MIN_ACTIVE)
    ) u_ch (
      .clk_100Hz  (clk_100Hz),
      .rst        (rst),
      .busy       (bus.busy_in[i]),
      .ack        (bus.ack[i]),
      .qualified  (qualified[i]),
      .done_pulse (bus.done_pulse[i]),
      .pending    (bus.pending[i]),
      .overrun    (bus.overrun[i])
    );
  end

  always_ff @(posedge clk_100Hz) begin
    if (rst)
      bus.any_done <= 1'b0;
    else
      bus.any_done <= |qualified;
  end

`ifdef CLEAN_FINISH_STICKY_EN
  logic [ID_W-1:0] done_id_c;

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    done_id_c = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.pending[i])
        done_id_c = ID_W'(i);
    end
  end

  assign bus.done_id    = done_id_c;
  assign bus.done_valid = |bus.pending;
`else
  assign bus.done_id    = '0;
  assign bus.done_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clean_finish_monitor.sv
// Directed plus randomized bench for clean_finish_monitor.
// It checks every cycle against a run-length reference model.
module tb_clean_finish_monitor;
  import clean_mon_pkg::*;

  localparam int N_CH       = 2;
  localparam int MIN_ACTIVE = 3;
  localparam int ID_W       = id_width(N_CH);
`ifdef CLEAN_FINISH_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // clock / reset
  logic clk_100Hz = 1'b0;
  logic rst       = 1'b1;
  always #5 clk_100Hz = ~clk_100Hz;

  clean_finish_monitor_if #(.N_CH(N_CH), .ID_W(ID_W)) bus ();

  clean_finish_monitor #(
    .N_CH(N_CH), .MIN_ACTIVE(MIN_ACTIVE), .ID_W(ID_W)
  ) dut (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state. run[i] is the number of consecutive high samples since
  // the last low sample or reset. It is unbounded.
  int              run [N_CH];
  logic [N_CH-1:0] exp_pulse = '0;
  logic            exp_any   = 1'b0;
  logic [N_CH-1:0] exp_pend  = '0;
  logic [N_CH-1:0] exp_ovr   = '0;
  logic            exp_valid = 1'b0;
  logic [ID_W-1:0] exp_id    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [N_CH-1:0] b, input logic [N_CH-1:0] a, input logic r);
    logic [N_CH-1:0] fin;
    logic [N_CH-1:0] pend_next;
    logic [N_CH-1:0] ovr_next;
    fin = '0;
    if (r) begin
      for (int i = 0; i < N_CH; i++) run[i] = 0;
      exp_pend = '0;
      exp_ovr  = '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // A finish is a low sample that ends a high run of at least MIN_ACTIVE.
        fin[i] = !b[i] && (run[i] >= MIN_ACTIVE);
        run[i] = b[i] ? run[i] + 1 : 0;
      end
      pend_next = exp_pend;
      ovr_next  = exp_ovr;
      for (int i = 0; i < N_CH; i++) begin
        if (fin[i] && exp_pend[i] && !a[i]) ovr_next[i] = 1'b1;
        else if (a[i])                      ovr_next[i] = 1'b0;
        if (fin[i])     pend_next[i] = 1'b1;
        else if (a[i])  pend_next[i] = 1'b0;
      end
      exp_pend = STICKY ? pend_next : '0;
      exp_ovr  = STICKY ? ovr_next  : '0;
    end
    exp_pulse = fin;
    exp_any   = |fin;
    exp_valid = |exp_pend;
    exp_id    = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (exp_pend[i]) exp_id = ID_W'(i);
  endtask

  // driver: apply one cycle of inputs, advance model at the edge, check #1 later
  task automatic cyc(input logic [N_CH-1:0] b, input logic [N_CH-1:0] a, input logic r);
    bus.busy_in = b;
    bus.ack     = a;
    rst         = r;
    @(posedge clk_100Hz);
    model_edge(b, a, r);
    #1;
    check("done_pulse", 32'(bus.done_pulse), 32'(exp_pulse));
    check("any_done",   32'(bus.any_done),   32'(exp_any));
    check("pending",    32'(bus.pending),    32'(exp_pend));
    check("overrun",    32'(bus.overrun),    32'(exp_ovr));
    check("done_valid", 32'(bus.done_valid), 32'(exp_valid));
    check("done_id",    32'(bus.done_id),    32'(exp_id));
  endtask

  logic [N_CH-1:0] rb;
  logic [N_CH-1:0] ra;

  initial begin
    for (int i = 0; i < N_CH; i++) run[i] = 0;
    bus.busy_in = '0;
    bus.ack     = '0;

    cyc(2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 1'b1);

    // ch0 long busy, qualified finish
    repeat (5) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);

    // ch1 glitch of 2 samples, then exactly MIN_ACTIVE samples
    repeat (2) cyc(2'b10, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    repeat (3) cyc(2'b10, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b11, 1'b0);

    // simultaneous finishes, then ack ch0 exposes ch1
    repeat (4) cyc(2'b11, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b01, 1'b0);
    cyc(2'b00, 2'b10, 1'b0);

    // overrun on ch0, then ack coincident with a third finish
    repeat (3) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    repeat (3) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    repeat (3) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b01, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b11, 1'b0);

    // reset right after a qualified fall
    repeat (3) cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b1);

    // busy held through reset, short run after release is a glitch
    cyc(2'b11, 2'b00, 1'b1);
    repeat (2) cyc(2'b11, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);

    // randomized phase: busy levels with random dwell, sparse acks and resets
    rb = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
      for (int i = 0; i < N_CH; i++)
        ra[i] = ($urandom_range(0, 5) == 0);
      cyc(rb, ra, ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
